// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation and state encodings,
// default latencies, and the behavioural 64-bit result function.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } mdu_state_e;

    localparam int MDU_MULT_CYCLES_DEF = 5;
    localparam int MDU_DIV_CYCLES_DEF  = 10;

    // Returns {hi, lo}; a zero divisor yields 0 and is suppressed at commit.
    function automatic logic [63:0] mdu_compute(input mdu_op_e op_v,
                                                input logic [31:0] a_v,
                                                input logic [31:0] b_v);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [31:0] qa;
        logic signed [31:0] qb;
        logic [63:0]        res;
        sa  = {{32{a_v[31]}}, a_v};
        sb  = {{32{b_v[31]}}, b_v};
        qa  = a_v;
        qb  = b_v;
        res = 64'd0;
        case (op_v)
            MDU_MULT:  res = sa * sb;
            MDU_MULTU: res = {32'd0, a_v} * {32'd0, b_v};
            MDU_DIV: begin
                if (b_v == 32'd0) begin
                    res = 64'd0;
                end else if ((a_v == 32'h8000_0000) && (b_v == 32'hFFFF_FFFF)) begin
                    res = {32'd0, 32'h8000_0000};
                end else begin
                    res = {32'(qa % qb), 32'(qa / qb)};
                end
            end
            MDU_DIVU: begin
                if (b_v == 32'd0) begin
                    res = 64'd0;
                end else begin
                    res = {a_v % b_v, a_v / b_v};
                end
            end
            default: res = 64'd0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mdu_execute.sv
// Execute-stage multiply/divide unit owning HI/LO; multi-cycle ops hold busy for a
// fixed latency and commit their pending result on the final busy edge.
module mdu_execute
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      p_hi_q, p_hi_d;
    logic [31:0]      p_lo_q, p_lo_d;
    logic             nocommit_q, nocommit_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic             busy_q, busy_d;
    logic [63:0]      result_s;
    mdu_op_e          op_s;

    assign op_s     = mdu_op_e'(op);
    assign result_s = mdu_compute(op_s, a, b);

    // Next-state: accept in IDLE only, count down while busy, commit at zero.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        p_hi_d     = p_hi_q;
        p_lo_d     = p_lo_q;
        nocommit_d = nocommit_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (op_s)
                        MDU_MULT, MDU_MULTU: begin
                            p_hi_d     = result_s[63:32];
                            p_lo_d     = result_s[31:0];
                            nocommit_d = 1'b0;
                            cnt_d      = CNT_W'(MULT_CYCLES - 1);
                            state_d    = MUL;
                        end
                        MDU_DIV, MDU_DIVU: begin
                            p_hi_d     = result_s[63:32];
                            p_lo_d     = result_s[31:0];
                            nocommit_d = (b == 32'd0);
                            cnt_d      = CNT_W'(DIV_CYCLES - 1);
                            state_d    = DIV;
                        end
                        MDU_MTHI: hi_d = a;
                        MDU_MTLO: lo_d = a;
                        default: begin
                            state_d = IDLE;
                        end
                    endcase
                end else begin
                    state_d = IDLE;
                end
            end
            MUL, DIV: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    if (!nocommit_q) begin
                        hi_d = p_hi_q;
                        lo_d = p_lo_q;
                    end else begin
                        hi_d = hi_q;
                    end
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and architectural registers; reset aborts any in-flight operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            p_hi_q     <= 32'd0;
            p_lo_q     <= 32'd0;
            nocommit_q <= 1'b0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            p_hi_q     <= p_hi_d;
            p_lo_q     <= p_lo_d;
            nocommit_q <= nocommit_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_execute.sv
// Scoreboard bench for mdu_execute: expected {hi,lo} queued at issue, compared at commit.
module tb_mdu_execute;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] sb_q[$];
    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;

    mdu_execute #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint          sx, sy, q, r;
        longint unsigned ux, uy, uq, ur;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        if (o == MDU_MULT) return 64'(sx * sy);
        if (o == MDU_MULTU) return 64'(ux * uy);
        if (y == 32'd0) return {hi_m, lo_m};
        if (o == MDU_DIV) begin
            q = sx / sy;
            r = sx - q * sy;
            return {r[31:0], q[31:0]};
        end
        uq = ux / uy;
        ur = ux - uq * uy;
        return {ur[31:0], uq[31:0]};
    endfunction

    task automatic run_md(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int n, input string tag);
        int          cyc;
        logic [63:0] e;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        sb_q.push_back(model(o, x, y));
        @(negedge clk);
        start = 1'b0; a = 32'd0; b = 32'd0;
        cyc = 0;
        while (busy && cyc < 200) begin
            check_val({tag, "_hold"}, {hi, lo}, {hi_m, lo_m});
            cyc++;
            @(negedge clk);
        end
        check_val({tag, "_busy_len"}, 64'(cyc), 64'(n));
        check_val({tag, "_sb_depth"}, 64'(sb_q.size()), 64'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val({tag, "_result"}, {hi, lo}, e);
            hi_m = e[63:32];
            lo_m = e[31:0];
        end
    endtask

    task automatic run_mt(input logic [2:0] o, input logic [31:0] x, input string tag);
        @(negedge clk);
        start = 1'b1; op = o; a = x;
        @(negedge clk);
        start = 1'b0; a = 32'd0;
        if (o == MDU_MTHI) hi_m = x;
        else lo_m = x;
        check_val({tag, "_hilo"}, {hi, lo}, {hi_m, lo_m});
        check_val({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
        repeat (2) @(negedge clk);
        check_val("reset_state", {31'd0, busy, hi, lo}, 64'd0);
        reset = 1'b1;

        run_md(MDU_MULT,  32'hFFFF_FFFF, 32'd2, 5,  "mult_neg");
        check_val("mult_neg_const", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFE});
        run_md(MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 5,  "multu");
        check_val("multu_const", {hi, lo}, {32'h0000_0001, 32'hFFFF_FFFE});
        run_md(MDU_DIV,   32'hFFFF_FFF9, 32'd2, 10, "div_neg");
        check_val("div_neg_const", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_md(MDU_DIVU,  32'd7,         32'd2, 10, "divu");
        check_val("divu_const", {hi, lo}, {32'd1, 32'd3});
        run_md(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, "div_ovf");
        check_val("div_ovf_const", {hi, lo}, {32'd0, 32'h8000_0000});

        for (int i = 0; i < 3; i++) begin
            run_md(MDU_MULT, $urandom, $urandom, 5, "mult_rnd");
            run_md(MDU_DIV,  $urandom, $urandom_range(32'hFFFF, 1), 10, "div_rnd");
        end

        run_mt(MDU_MTHI, 32'h11, "mthi");
        run_mt(MDU_MTLO, 32'h22, "mtlo");
        run_md(MDU_DIVU, 32'd99, 32'd0, 10, "divu_zero");
        check_val("div0_keep", {hi, lo}, {32'h11, 32'h22});
        run_md(MDU_DIV,  32'd99, 32'd0, 10, "div_zero");

        // MULT in flight, a stray MTLO is ignored, then reset aborts it at busy cycle 3.
        @(negedge clk);
        start = 1'b1; op = MDU_MULT; a = 32'd3; b = 32'd5;
        @(negedge clk);
        op = MDU_MTLO; a = 32'hDEAD_BEEF;
        check_val("abort_busy_c1", 64'(busy), 64'd1);
        @(negedge clk);
        start = 1'b0; a = 32'd0; b = 32'd0;
        check_val("ignored_start", {hi, lo}, {32'h11, 32'h22});
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check_val("async_reset", {31'd0, busy, hi, lo}, 64'd0);
        hi_m = 32'd0; lo_m = 32'd0;
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        check_val("no_commit_after_reset", {31'd0, busy, hi, lo}, 64'd0);

        run_md(MDU_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 5, "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_execute.md
# mdu_execute

Multiply/divide unit for the Execute stage, fed by the Decode/Execute pipeline register with forwarded operands and the decoded operation. It runs MULT/MULTU/DIV/DIVU as multi-cycle operations that own the HI/LO architectural registers, and handles MTHI/MTLO writes. It exports `busy`, which the hazard unit uses to stall MD-class instructions in Decode. HI/LO feed the MFHI/MFLO result mux in Execute.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU.
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU.
- `clk` input 1: the single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-low; clears all state immediately.
- `start` input 1: qualified MD instruction present in Execute this cycle.
- `op` input 3: operation code from `mdu_pkg`: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- `a` input 32: forwarded rs value (dividend / multiplicand / MTHI/MTLO source).
- `b` input 32: forwarded rt value (divisor / multiplier).
- `busy` output 1: a multi-cycle operation is in progress.
- `hi` output 32: architectural HI register.
- `lo` output 32: architectural LO register.

## Operation
- States:
  - IDLE: accepts work.
  - MUL: running MULT/MULTU.
  - DIV: running DIV/DIVU.
- Acceptance:
  - `start` is accepted only in IDLE (`busy`==0).
  - `start` while busy is ignored, with no side effects. The hazard unit keeps this from happening, but the unit must still tolerate it.
- MTHI/MTLO:
  - Accepted start writes `a` into `hi`/`lo` at that edge.
  - State stays IDLE and `busy` stays 0.
- MULT/MULTU/DIV/DIVU:
  - At the accepting edge, the unit latches the 64-bit result into pending registers `p_hi`/`p_lo` and loads the cycle counter.
  - State moves to MUL or DIV.
  - `hi`/`lo` do not change until commit.
- MULT: signed 32x32 to 64 bits; `hi`=[63:32], `lo`=[31:0]. MULTU: the same, unsigned.
- DIV:
  - Signed; `lo`=quotient, truncated toward zero; `hi`=remainder, with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0.
- DIVU: unsigned quotient and remainder.
- Divide by zero (`b`==0, DIV or DIVU):
  - Full DIV_CYCLES busy period runs.
  - No commit; `hi`/`lo` keep their old values.
- Commit: at the final busy edge, `hi`/`lo` load from the pending registers, `busy` falls, and state returns to IDLE.

## Timing
- Counter width: $clog2(max(MULT_CYCLES, DIV_CYCLES)) + 1 bits. It loads N-1 on accept, decrements each cycle, and commits when it reaches 0.
- Accept at edge T0:
  - `busy`=1 for cycles T0..T0+N, i.e. exactly N cycles.
  - Commit at edge T0+N; `busy`=0 and new `hi`/`lo` are visible after that edge.
- MFHI/MFLO issued in the cycle after `busy` falls reads the committed value.
- Back-to-back:
  - A `start` in the cycle where `busy`=1 is ignored, even if that cycle's edge is the commit edge.
  - The earliest accept of the next operation is the edge after commit.
- Reset (`reset`=0):
  - Takes effect asynchronously at any time, including mid-operation. An in-progress operation is aborted with no commit.
  - `hi`=0, `lo`=0, `busy`=0, state=IDLE, counter=0, `p_hi`/`p_lo`=0.
- After `reset` rises, the first edge can accept.
- No combinational path from `start`/`op`/`a`/`b` to any output; all outputs are registered.

## Structure
- Shared package `mdu_pkg`:
  - `op` encodings: MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO.
  - State encodings: IDLE, MUL, DIV.
  - Default cycle constants.
- The decoder that generates `op` and `start` imports the same package.
- Single module, no sub-module: the arithmetic is behavioural and the datapath is small.
- Optional split: the signed/unsigned result function as a sub-module `mdu_arith`, if synthesis timing requires it.

## Test plan
- Reset, then MULT with `a`=0xFFFFFFFF, `b`=2:
  - `busy` high for exactly 5 cycles, with `hi`/`lo` still 0 throughout.
  - Then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFE.
- MULTU with `a`=0xFFFFFFFF, `b`=2 gives `hi`=0x00000001, `lo`=0xFFFFFFFE after 5 cycles.
- DIV with `a`=0xFFFFFFF9 (-7), `b`=2:
  - `busy` for 10 cycles.
  - Then `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIVU with `a`=7, `b`=2 gives `lo`=3, `hi`=1.
- Divide by zero: set `hi`=0x11 and `lo`=0x22 via MTHI/MTLO, then DIVU with `b`=0:
  - `busy` for 10 cycles.
  - `hi`/`lo` remain 0x11/0x22.
- Start ignored, then reset mid-operation:
  - MULT, then a `start` with MTLO asserted during `busy`: it is ignored.
  - Then `reset` low at busy cycle 3: `busy`, `hi`, `lo` are 0 immediately.
  - No commit occurs after `reset` rises.
